// File: rtl/qea_engine.sv
// Fixed-point state-vector quantum gate engine: executes a context-RAM gate program
// over a banked state RAM (PE_NUM amplitudes per row), one row or row pair at a time.
module qea_engine #(
   parameter int PE_NUM_WIDTH            = 2,
   parameter int PE_NUM                  = 4,
   parameter int DATA_WIDTH              = 32,
   parameter int MAX_QBIT_WIDTH          = 6,
   parameter int ALU_DATA_WIDTH          = DATA_WIDTH,
   parameter int STATE_DATA_WIDTH        = 2*DATA_WIDTH,
   parameter int STATE_ADDR_WIDTH        = 16,
   parameter int GATE_DATA_WIDTH         = 2*DATA_WIDTH,
   parameter int GATE_ADDR_WIDTH         = 6,
   parameter int GATE_CONTEXT_DATA_WIDTH = 2*DATA_WIDTH,
   parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
   parameter int NUM_FRAC_BIT            = 30
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 i_start,
   input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
   input  logic                                 i_ctx_en,
   input  logic                                 i_ctx_wea,
   input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ctx_addr,
   input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
   input  logic                                 i_state_ena,
   input  logic                                 i_state_wea,
   input  logic [STATE_ADDR_WIDTH-1:0]          i_state_addra,
   input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dina,
   output logic                                 o_complete,
   output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dout
);
   localparam int DW  = DATA_WIDTH;
   localparam int SD  = STATE_DATA_WIDTH;
   localparam int RW  = PE_NUM*SD;
   localparam int AIW = STATE_ADDR_WIDTH + PE_NUM_WIDTH;
   localparam int CW  = GATE_CONTEXT_DATA_WIDTH;
   localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_LOAD = 3'd2,
                          ST_EXEC = 3'd3, ST_DONE = 3'd4;

   logic [CW-1:0]                      ctx_mem [2**GATE_CONTEXT_ADDR_WIDTH];
   logic [CW-1:0]                      ctx_q;
   logic [RW-1:0]                      state_mem [2**STATE_ADDR_WIDTH];
   logic [RW-1:0]                      state_q;
   logic [2:0]                         fsm_reg, sub_reg;
   logic [GATE_CONTEXT_ADDR_WIDTH:0]   pc_reg;
   logic [3:0]                         op_reg;
   logic [MAX_QBIT_WIDTH-1:0]          t_reg, c_reg;
   logic [GATE_DATA_WIDTH-1:0]         u_reg [4];
   logic [STATE_ADDR_WIDTH-1:0]        cnt_reg;
   logic [RW-1:0]                      a_reg, b_reg;
   logic                               complete_reg;

   function automatic logic [SD-1:0] cmul(input logic [SD-1:0] a, input logic [SD-1:0] b);
      logic signed [2*DW-1:0] ar, ai, br, bi;
      ar = {{DW{a[SD-1]}}, a[SD-1:DW]};
      ai = {{DW{a[DW-1]}}, a[DW-1:0]};
      br = {{DW{b[SD-1]}}, b[SD-1:DW]};
      bi = {{DW{b[DW-1]}}, b[DW-1:0]};
      cmul = {DW'((ar*br) >>> NUM_FRAC_BIT) - DW'((ai*bi) >>> NUM_FRAC_BIT),
              DW'((ar*bi) >>> NUM_FRAC_BIT) + DW'((ai*br) >>> NUM_FRAC_BIT)};
   endfunction

   function automatic logic [SD-1:0] cadd(input logic [SD-1:0] x, input logic [SD-1:0] y);
      cadd = {x[SD-1:DW] + y[SD-1:DW], x[DW-1:0] + y[DW-1:0]};
   endfunction

   function automatic logic bit_of(input logic [AIW-1:0] v, input logic [MAX_QBIT_WIDTH-1:0] b);
      bit_of = |(v & (AIW'(1) << b));
   endfunction

   logic idle;
   assign idle = (fsm_reg == ST_IDLE);

   // Context port: host owns it while idle, the program counter otherwise.
   logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ctx_addr;
   logic                               ctx_en, ctx_we;
   assign ctx_addr = idle ? i_ctx_addr : pc_reg[GATE_CONTEXT_ADDR_WIDTH-1:0];
   assign ctx_en   = idle ? i_ctx_en : 1'b1;
   assign ctx_we   = idle & i_ctx_en & i_ctx_wea;

   always_ff @(posedge clk) begin
      if (ctx_en) begin
         if (ctx_we) ctx_mem[ctx_addr] <= i_ctx_data;
         ctx_q <= ctx_mem[ctx_addr];
      end
   end

   // Pair geometry: a target below PE_NUM_WIDTH pairs lanes inside one row,
   // otherwise row_a (bit t-PW clear) pairs with row_b (bit set).
   logic                          in_row, last, skip;
   logic [MAX_QBIT_WIDTH-1:0]     kk, rows_log;
   logic [STATE_ADDR_WIDTH-1:0]   low_mask, row_a, row_b;
   logic [STATE_ADDR_WIDTH:0]     iters, iters_eff;
   assign in_row    = t_reg < MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
   assign kk        = t_reg - MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
   assign low_mask  = (STATE_ADDR_WIDTH'(1) << kk) - STATE_ADDR_WIDTH'(1);
   assign row_a     = in_row ? cnt_reg : (((cnt_reg & ~low_mask) << 1) | (cnt_reg & low_mask));
   assign row_b     = in_row ? cnt_reg : (row_a | (STATE_ADDR_WIDTH'(1) << kk));
   assign rows_log  = i_qbit_num - MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
   assign iters     = (STATE_ADDR_WIDTH+1)'(1) << rows_log;
   assign iters_eff = in_row ? iters : (iters >> 1);
   assign last      = ({1'b0, cnt_reg} == iters_eff - (STATE_ADDR_WIDTH+1)'(1));
   assign skip      = (t_reg >= i_qbit_num) ||
                      (op_reg == 4'd2 && (c_reg >= i_qbit_num || c_reg == t_reg));

   // Lane datapath: sub-step 3 rewrites row_a, sub-step 4 rewrites row_b.
   logic                 phase_b;
   logic [RW-1:0]        self_row, other_row, new_row;
   logic [SD-1:0]        self_lane [PE_NUM];
   logic [SD-1:0]        other_lane [PE_NUM];
   logic [STATE_ADDR_WIDTH-1:0] self_idx;
   assign phase_b   = (sub_reg == 3'd4);
   assign self_row  = phase_b ? b_reg : a_reg;
   assign other_row = in_row ? self_row : (phase_b ? a_reg : b_reg);
   assign self_idx  = phase_b ? row_b : row_a;

   genvar gi;
   generate
      for (gi = 0; gi < PE_NUM; gi++) begin : g_lane
         logic [PE_NUM_WIDTH-1:0] partner_sel;
         logic [AIW-1:0]          amp_idx;
         logic [SD-1:0]           partner, lo_sum, hi_sum;
         logic                    apply;
         assign self_lane[gi]  = self_row[(PE_NUM-gi)*SD-1 -: SD];
         assign other_lane[gi] = other_row[(PE_NUM-gi)*SD-1 -: SD];
         assign partner_sel = PE_NUM_WIDTH'(gi) ^ (PE_NUM_WIDTH'(1) << t_reg);
         assign partner     = in_row ? self_lane[partner_sel] : other_lane[gi];
         assign amp_idx     = {self_idx, PE_NUM_WIDTH'(gi)};
         assign apply       = (op_reg != 4'd2) | bit_of(amp_idx, c_reg);
         assign lo_sum      = cadd(cmul(u_reg[0], self_lane[gi]), cmul(u_reg[1], partner));
         assign hi_sum      = cadd(cmul(u_reg[2], partner), cmul(u_reg[3], self_lane[gi]));
         assign new_row[(PE_NUM-gi)*SD-1 -: SD] =
            !apply ? self_lane[gi] : (bit_of(amp_idx, t_reg) ? hi_sum : lo_sum);
      end
   endgenerate

   logic [STATE_ADDR_WIDTH-1:0] st_addr;
   logic                        st_en, st_we;
   logic [RW-1:0]               st_din;
   assign st_addr = idle ? i_state_addra
                         : ((sub_reg == 3'd1 || sub_reg == 3'd4) ? row_b : row_a);
   assign st_en   = idle ? i_state_ena : 1'b1;
   assign st_we   = idle ? (i_state_ena & i_state_wea)
                         : (fsm_reg == ST_EXEC && (sub_reg == 3'd3 || sub_reg == 3'd4));
   assign st_din  = idle ? i_state_dina : new_row;

   always_ff @(posedge clk) begin
      if (st_we) state_mem[st_addr] <= st_din;
   end

   always_ff @(posedge clk) begin
      if (rst_n)      state_q <= '0;
      else if (st_en) state_q <= state_mem[st_addr];
   end

   always_ff @(posedge clk) begin
      if (fsm_reg == ST_LOAD && sub_reg != 3'd0) u_reg[sub_reg[1:0] - 2'd1] <= ctx_q;
      if (fsm_reg == ST_EXEC && sub_reg == 3'd1) a_reg <= state_q;
      if (fsm_reg == ST_EXEC && sub_reg == 3'd2) b_reg <= state_q;
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         fsm_reg      <= ST_IDLE;
         sub_reg      <= 3'd0;
         pc_reg       <= '0;
         cnt_reg      <= '0;
         op_reg       <= 4'd0;
         t_reg        <= '0;
         c_reg        <= '0;
         complete_reg <= 1'b0;
      end else begin
         case (fsm_reg)
            ST_IDLE: if (i_start) begin
               fsm_reg      <= ST_FETCH;
               sub_reg      <= 3'd0;
               pc_reg       <= '0;
               complete_reg <= 1'b0;
            end
            ST_FETCH: begin
               if (pc_reg[GATE_CONTEXT_ADDR_WIDTH]) begin
                  fsm_reg <= ST_DONE;
               end else if (sub_reg == 3'd0) begin
                  sub_reg <= 3'd1;
               end else begin
                  op_reg  <= ctx_q[CW-1 -: 4];
                  t_reg   <= ctx_q[CW-5 -: MAX_QBIT_WIDTH];
                  c_reg   <= ctx_q[CW-5-MAX_QBIT_WIDTH -: MAX_QBIT_WIDTH];
                  pc_reg  <= pc_reg + 1'b1;
                  sub_reg <= 3'd0;
                  case (ctx_q[CW-1 -: 4])
                     4'hF:       fsm_reg <= ST_DONE;
                     4'h1, 4'h2: fsm_reg <= ST_LOAD;
                     default:    fsm_reg <= ST_FETCH;
                  endcase
               end
            end
            ST_LOAD: begin
               if (sub_reg == 3'd4) begin
                  fsm_reg <= skip ? ST_FETCH : ST_EXEC;
                  sub_reg <= 3'd0;
                  cnt_reg <= '0;
               end else begin
                  pc_reg  <= pc_reg + 1'b1;
                  sub_reg <= sub_reg + 3'd1;
               end
            end
            ST_EXEC: begin
               case (sub_reg)
                  3'd0:    sub_reg <= 3'd1;
                  3'd1:    sub_reg <= in_row ? 3'd3 : 3'd2;
                  3'd2:    sub_reg <= 3'd3;
                  default: begin
                     if (sub_reg == 3'd3 && !in_row) begin
                        sub_reg <= 3'd4;
                     end else begin
                        sub_reg <= 3'd0;
                        if (last) fsm_reg <= ST_FETCH;
                        else      cnt_reg <= cnt_reg + 1'b1;
                     end
                  end
               endcase
            end
            ST_DONE: begin
               complete_reg <= 1'b1;
               fsm_reg      <= ST_IDLE;
            end
            default: fsm_reg <= ST_IDLE;
         endcase
      end
   end

   assign o_complete   = complete_reg;
   assign o_state_dout = state_q;
endmodule

// File: tb/tb_qea_engine.sv
// Self-checking bench for qea_engine: directed gate programs plus randomized programs,
// compared against an amplitude-array reference model.
module tb_qea_engine;
   localparam int RW = 256;

   logic            clk = 1'b0;
   logic            rst_n, i_start, i_ctx_en, i_ctx_wea, i_state_ena, i_state_wea;
   logic [5:0]      i_qbit_num;
   logic [15:0]     i_ctx_addr, i_state_addra;
   logic [63:0]     i_ctx_data;
   logic [RW-1:0]   i_state_dina, o_state_dout;
   logic            o_complete;

   qea_engine dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_qbit_num(i_qbit_num),
      .i_ctx_en(i_ctx_en), .i_ctx_wea(i_ctx_wea), .i_ctx_addr(i_ctx_addr),
      .i_ctx_data(i_ctx_data), .i_state_ena(i_state_ena), .i_state_wea(i_state_wea),
      .i_state_addra(i_state_addra), .i_state_dina(i_state_dina),
      .o_complete(o_complete), .o_state_dout(o_state_dout)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          op, t, c;
      logic [63:0] u0, u1, u2, u3;
   } gate_t;

   int            checks = 0, failures = 0;
   int            nq;
   int            mre [64];
   int            mim [64];
   gate_t         gq [$];
   logic [RW-1:0] dut_rows [16];
   int            last_cycles;

   task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int fmul(input int x, input int y);
      longint p;
      p = longint'(x) * longint'(y);
      return int'(p >>> 30);
   endfunction

   function automatic void cmul(input logic [63:0] u, input int ar, input int ai,
                                output int r, output int i);
      int ur, ui;
      ur = u[63:32];
      ui = u[31:0];
      r = fmul(ur, ar) - fmul(ui, ai);
      i = fmul(ur, ai) + fmul(ui, ar);
   endfunction

   function automatic void model_gate(input gate_t g);
      int r0, i0, r1, i1, a0r, a0i, a1r, a1i, j;
      if (g.op != 1 && g.op != 2) return;
      if (g.t >= nq) return;
      if (g.op == 2 && (g.c >= nq || g.c == g.t)) return;
      for (int i = 0; i < (1 << nq); i++) begin
         if (((i >> g.t) & 1) == 0 && (g.op == 1 || ((i >> g.c) & 1) == 1)) begin
            j = i | (1 << g.t);
            a0r = mre[i]; a0i = mim[i]; a1r = mre[j]; a1i = mim[j];
            cmul(g.u0, a0r, a0i, r0, i0);
            cmul(g.u1, a1r, a1i, r1, i1);
            mre[i] = r0 + r1; mim[i] = i0 + i1;
            cmul(g.u2, a0r, a0i, r0, i0);
            cmul(g.u3, a1r, a1i, r1, i1);
            mre[j] = r0 + r1; mim[j] = i0 + i1;
         end
      end
   endfunction

   function automatic logic [RW-1:0] pack_row(input int r);
      logic [RW-1:0] v;
      for (int k = 0; k < 4; k++) v[(4-k)*64-1 -: 64] = {mre[r*4+k], mim[r*4+k]};
      return v;
   endfunction

   function automatic logic [31:0] q30(input real x);
      return 32'($rtoi(x * 1073741824.0));
   endfunction

   task automatic set_basis(input int n, input int idx);
      nq = n;
      for (int i = 0; i < 64; i++) begin mre[i] = 0; mim[i] = 0; end
      mre[idx] = 32'h40000000;
   endtask

   task automatic add(input int op, input int t, input int c, input logic [63:0] u0,
                      input logic [63:0] u1, input logic [63:0] u2, input logic [63:0] u3);
      gate_t g;
      g.op = op; g.t = t; g.c = c; g.u0 = u0; g.u1 = u1; g.u2 = u2; g.u3 = u3;
      gq.push_back(g);
   endtask

   // Program and initial state are written in the same cycles.
   task automatic load_prog();
      logic [63:0] words [$];
      logic [63:0] h;
      int nrows, nw;
      foreach (gq[g]) begin
         h = '0;
         h[63:60] = gq[g].op[3:0];
         h[59:54] = gq[g].t[5:0];
         h[53:48] = gq[g].c[5:0];
         words.push_back(h);
         if (gq[g].op == 1 || gq[g].op == 2) begin
            words.push_back(gq[g].u0); words.push_back(gq[g].u1);
            words.push_back(gq[g].u2); words.push_back(gq[g].u3);
         end
      end
      h = '0;
      h[63:60] = 4'hF;
      words.push_back(h);
      nw = words.size();
      nrows = (1 << nq) / 4;
      for (int i = 0; i < ((nw > nrows) ? nw : nrows); i++) begin
         i_ctx_en      = (i < nw);
         i_ctx_wea     = (i < nw);
         i_ctx_addr    = 16'(i);
         i_ctx_data    = (i < nw) ? words[i] : 64'h0;
         i_state_ena   = (i < nrows);
         i_state_wea   = (i < nrows);
         i_state_addra = 16'(i);
         i_state_dina  = (i < nrows) ? pack_row(i) : '0;
         @(posedge clk); #1;
      end
      i_ctx_en = 0; i_ctx_wea = 0; i_state_ena = 0; i_state_wea = 0;
      i_qbit_num = nq[5:0];
   endtask

   task automatic start_and_wait(input string name);
      int bound, cyc;
      bound = 4;
      foreach (gq[g]) bound += (gq[g].op == 1 || gq[g].op == 2) ? (1 << nq) + 16 : 4;
      i_start = 1;
      @(posedge clk); #1;
      i_start = 0;
      check({name, "_clr"}, RW'(o_complete), RW'(0));
      cyc = 0;
      while (!o_complete && cyc < bound) begin
         @(posedge clk); #1;
         cyc++;
      end
      last_cycles = cyc;
      check({name, "_done"}, RW'(o_complete), RW'(1));
      check({name, "_lat"}, RW'(cyc <= bound), RW'(1));
      repeat (2) @(posedge clk);
      #1;
      check({name, "_hold"}, RW'(o_complete), RW'(1));
   endtask

   task automatic read_row(input int r, input logic wr_zero, output logic [RW-1:0] d);
      i_state_ena = 1; i_state_wea = wr_zero; i_state_addra = 16'(r); i_state_dina = '0;
      @(posedge clk); #1;
      d = o_state_dout;
      i_state_ena = 0; i_state_wea = 0;
   endtask

   task automatic verify(input string name, input logic wr_zero);
      logic [RW-1:0] d;
      for (int r = 0; r < (1 << nq) / 4; r++) begin
         read_row(r, wr_zero, d);
         dut_rows[r] = d;
         check($sformatf("%s_r%0d", name, r), d, pack_row(r));
      end
   endtask

   task automatic run_prog(input string name);
      load_prog();
      start_and_wait(name);
      foreach (gq[g]) model_gate(gq[g]);
      verify(name, 1'b0);
      $display("run %s n=%0d gates=%0d cycles=%0d", name, nq, gq.size(), last_cycles);
   endtask

   logic [63:0] one, hh, hn, zero;
   logic [RW-1:0] exp_row;
   int ph_re, ph_im, dre, dim;

   initial begin
      one = 64'h40000000_00000000; hh = 64'h2D413CCD_00000000;
      hn = 64'hD2BEC333_00000000;  zero = 64'h0;
      rst_n = 1; i_start = 0; i_qbit_num = 6'd4;
      i_ctx_en = 0; i_ctx_wea = 0; i_ctx_addr = 0; i_ctx_data = 0;
      i_state_ena = 0; i_state_wea = 0; i_state_addra = 0; i_state_dina = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_complete", RW'(o_complete), RW'(0));
      check("rst_dout", o_state_dout, '0);
      rst_n = 0;

      // END only
      set_basis(4, 0); gq.delete();
      run_prog("end");
      check("end_lat4", RW'(last_cycles <= 4), RW'(1));
      exp_row = '0; exp_row[255:192] = one;
      check("end_row0", dut_rows[0], exp_row);

      // Hadamard on qubit 0
      set_basis(4, 0); gq.delete();
      add(1, 0, 0, hh, hh, hh, hn);
      run_prog("h0");
      exp_row = '0; exp_row[255:192] = hh; exp_row[191:128] = hh;
      check("h0_row0", dut_rows[0], exp_row);

      // X on qubit 3
      set_basis(4, 0); gq.delete();
      add(1, 3, 0, zero, one, one, zero);
      run_prog("x3");
      exp_row = '0; exp_row[255:192] = one;
      check("x3_row2", dut_rows[2], exp_row);
      check("x3_row0", dut_rows[0], '0);

      // Controlled-Z variants on |3>
      set_basis(4, 3); gq.delete();
      add(2, 1, 0, one, zero, zero, 64'hC0000000_00000000);
      run_prog("cz");
      exp_row = '0; exp_row[63:0] = 64'hC0000000_00000000;
      check("cz_row0", dut_rows[0], exp_row);
      exp_row[63:0] = one;
      set_basis(4, 3); gq.delete();
      add(2, 1, 2, one, zero, zero, 64'hC0000000_00000000);
      run_prog("cz_c2");
      check("cz_c2_row0", dut_rows[0], exp_row);
      set_basis(4, 3); gq.delete();
      add(2, 1, 1, one, zero, zero, 64'hC0000000_00000000);
      run_prog("cz_ct");
      check("cz_ct_row0", dut_rows[0], exp_row);

      // 4-qubit QFT, read back with destructive zero writes
      set_basis(4, 0); gq.delete();
      for (int j = 3; j >= 0; j--) begin
         add(1, j, 0, hh, hh, hh, hn);
         for (int m = j - 1; m >= 0; m--) begin
            ph_re = q30($cos(3.14159265358979 / (1 << (j - m))));
            ph_im = q30($sin(3.14159265358979 / (1 << (j - m))));
            add(2, j, m, one, zero, zero, {ph_re, ph_im});
         end
      end
      load_prog();
      start_and_wait("qft");
      foreach (gq[g]) model_gate(gq[g]);
      verify("qft", 1'b1);
      for (int i = 0; i < 16; i++) begin
         dre = int'(dut_rows[i/4][(4-(i%4))*64-1 -: 32]) - 32'h10000000;
         dim = int'(dut_rows[i/4][(4-(i%4))*64-33 -: 32]);
         check($sformatf("qft_tol%0d", i),
               RW'((dre >= -2 && dre <= 2) && (dim >= -2 && dim <= 2)), RW'(1));
      end
      for (int i = 0; i < 64; i++) begin mre[i] = 0; mim[i] = 0; end
      verify("qft_zeroed", 1'b0);
      $display("run qft n=4 gates=%0d cycles=%0d", gq.size(), last_cycles);

      // Randomized programs
      for (int p = 0; p < 10; p++) begin
         nq = $urandom_range(2, 6);
         for (int i = 0; i < 64; i++) begin mre[i] = $urandom; mim[i] = $urandom; end
         gq.delete();
         for (int g = 0; g < $urandom_range(1, 5); g++) begin
            int ops [6] = '{0, 1, 2, 1, 2, 7};
            add(ops[$urandom_range(0, 5)], $urandom_range(0, nq), $urandom_range(0, nq),
                {$urandom, $urandom}, {$urandom, $urandom},
                {$urandom, $urandom}, {$urandom, $urandom});
         end
         run_prog($sformatf("rnd%0d", p));
      end

      // Reset in the middle of a program aborts to idle
      set_basis(6, 5); gq.delete();
      add(1, 4, 0, hh, hh, hh, hn);
      add(1, 5, 0, hh, hh, hh, hn);
      load_prog();
      i_start = 1;
      @(posedge clk); #1;
      i_start = 0;
      repeat (20) @(posedge clk);
      #1;
      rst_n = 1;
      @(posedge clk); #1;
      rst_n = 0;
      check("midrst_complete", RW'(o_complete), RW'(0));
      check("midrst_dout", o_state_dout, '0);
      set_basis(4, 0); gq.delete();
      add(1, 2, 0, zero, one, one, zero);
      run_prog("after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
